// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_dma
//  Purpose  : Block-copy engine in front of a single-port data memory.
//             While idle, the core's address, write enable and write data
//             pass straight through to the memory. On Start the engine takes
//             the port, copies Length bytes from SrcAddr to DstAddr with
//             memmove semantics, pulses Done and hands the port back.
//             Each byte costs one read cycle and one write cycle, since the
//             memory reads combinationally and writes on the clock edge.
//  Ports    : Clk, Reset (async, active-low)
//             Start, SrcAddr, DstAddr, Length        - copy request
//             CoreAddr, CoreWriteEn, CoreDataIn      - core passthrough in
//             CoreDataOut                            - memory read data to core
//             Busy, Done                             - engine status
//             MemAddress, MemWriteEn, MemDataOut     - to memory
//             MemDataIn                              - from memory
//  Revision : 1.0  initial release
// ============================================================================
module mem_copy_dma #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [ADDR_W-1:0] Length,
   input  logic [ADDR_W-1:0] CoreAddr,
   input  logic              CoreWriteEn,
   input  logic [DATA_W-1:0] CoreDataIn,
   output logic [DATA_W-1:0] CoreDataOut,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] MemAddress,
   output logic              MemWriteEn,
   output logic [DATA_W-1:0] MemDataOut,
   input  logic [DATA_W-1:0] MemDataIn
);

   localparam logic [ADDR_W-1:0] c_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] c_zero = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_count;
   logic [DATA_W-1:0] r_data;
   logic              r_backward;
   logic              r_busy;
   logic              r_done;

   // Copying backward when the destination sits above the source keeps an
   // overlapping copy from overwriting source bytes before they are read.
   logic              w_backward;
   logic [ADDR_W-1:0] w_last_ofs;

   assign w_backward = (DstAddr > SrcAddr);
   assign w_last_ofs = Length - c_one;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= S_IDLE;
         r_src      <= c_zero;
         r_dst      <= c_zero;
         r_count    <= c_zero;
         r_data     <= '0;
         r_backward <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_busy <= 1'b1;
                  if (Length != c_zero) begin
                     r_state    <= S_READ;
                     r_count    <= Length;
                     r_backward <= w_backward;
                     r_src      <= w_backward ? (SrcAddr + w_last_ofs) : SrcAddr;
                     r_dst      <= w_backward ? (DstAddr + w_last_ofs) : DstAddr;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_data  <= MemDataIn;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_count <= r_count - c_one;
               r_src   <= r_backward ? (r_src - c_one) : (r_src + c_one);
               r_dst   <= r_backward ? (r_dst - c_one) : (r_dst + c_one);
               if (r_count == c_one) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_READ;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Port ownership mux: core traffic only reaches the memory in IDLE, so a
   // core write issued while busy is dropped rather than queued.
   always_comb begin
      MemAddress = CoreAddr;
      MemWriteEn = CoreWriteEn;
      MemDataOut = CoreDataIn;
      case (r_state)
         S_READ: begin
            MemAddress = r_src;
            MemWriteEn = 1'b0;
         end
         S_WRITE: begin
            MemAddress = r_dst;
            MemWriteEn = 1'b1;
            MemDataOut = r_data;
         end
         S_DONE: begin
            MemAddress = CoreAddr;
            MemWriteEn = 1'b0;
         end
         default: begin
            MemAddress = CoreAddr;
            MemWriteEn = CoreWriteEn;
            MemDataOut = CoreDataIn;
         end
      endcase
   end

   assign CoreDataOut = MemDataIn;
   assign Busy        = r_busy;
   assign Done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_dma
//  Purpose  : Self-checking bench for mem_copy_dma with a 256x8 memory model.
//             Expected read addresses and write (address, data) pairs are
//             queued when a copy is launched and compared as the engine
//             drives the memory port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_copy_dma;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic [7:0] SrcAddr = '0;
   logic [7:0] DstAddr = '0;
   logic [7:0] Length = '0;
   logic [7:0] CoreAddr = '0;
   logic       CoreWriteEn = 1'b0;
   logic [7:0] CoreDataIn = '0;
   logic [7:0] CoreDataOut;
   logic       Busy;
   logic       Done;
   logic [7:0] MemAddress;
   logic       MemWriteEn;
   logic [7:0] MemDataOut;
   logic [7:0] MemDataIn;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [7:0]  mem [256];
   logic [7:0]  rq [$];
   logic [15:0] wq [$];

   mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
      .CoreAddr(CoreAddr), .CoreWriteEn(CoreWriteEn), .CoreDataIn(CoreDataIn),
      .CoreDataOut(CoreDataOut), .Busy(Busy), .Done(Done),
      .MemAddress(MemAddress), .MemWriteEn(MemWriteEn),
      .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
   );

   always #5 Clk = ~Clk;

   // Memory: combinational read, write on posedge.
   assign MemDataIn = mem[MemAddress];
   always @(posedge Clk) begin
      if (MemWriteEn) mem[MemAddress] <= MemDataOut;
   end

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   // Scoreboard side: every engine-owned memory cycle is matched against the
   // queued expectation. A write with an empty queue is an unexpected write.
   always @(negedge Clk) begin
      if (Reset && Done) done_cnt++;
      if (Reset && Busy) begin
         if (MemWriteEn) begin
            if (wq.size() == 0) chk("unexpected_write", {24'd0, MemAddress}, 32'hFFFF);
            else begin
               logic [15:0] e;
               e = wq.pop_front();
               chk("write_addr", {24'd0, MemAddress}, {24'd0, e[15:8]});
               chk("write_data", {24'd0, MemDataOut}, {24'd0, e[7:0]});
            end
         end else if (!Done) begin
            if (rq.size() == 0) chk("unexpected_read", {24'd0, MemAddress}, 32'hFFFF);
            else chk("read_addr", {24'd0, MemAddress}, {24'd0, rq.pop_front()});
         end
      end
   end

   task automatic core_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge Clk);
      CoreAddr = a; CoreDataIn = d; CoreWriteEn = 1'b1;
      @(negedge Clk);
      CoreWriteEn = 1'b0;
   endtask

   // mode: 0 = plain copy, 1 = core write + second Start mid-copy,
   //       2 = reset asserted in cycle 5
   task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                           input logic [7:0] len, input int mode, input string tag);
      logic [7:0] snap [256];
      bit         back;
      int         cyc;
      int         idx;
      bit         busy_ok;
      int         d0;
      back = (dst > src);
      for (int k = 0; k < int'(len); k++) snap[k] = mem[8'(src + 8'(k))];
      for (int i = 0; i < int'(len); i++) begin
         idx = back ? (int'(len) - 1 - i) : i;
         rq.push_back(8'(src + 8'(idx)));
         wq.push_back({8'(dst + 8'(idx)), snap[idx]});
      end
      d0 = done_cnt;
      @(negedge Clk);
      SrcAddr = src; DstAddr = dst; Length = len; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      cyc = 1;
      busy_ok = 1'b1;
      while (!Done && cyc < 600) begin
         if (!Busy) busy_ok = 1'b0;
         if (mode == 2 && cyc == 5) begin
            Reset = 1'b0;
            #1;
            chk({tag, "_abort_busy"}, {31'd0, Busy}, 32'd0);
            chk({tag, "_abort_done"}, {31'd0, Done}, 32'd0);
            rq.delete();
            wq.delete();
            @(negedge Clk);
            Reset = 1'b1;
            @(negedge Clk);
            chk({tag, "_abort_no_done"}, done_cnt - d0, 32'd0);
            return;
         end
         if (mode == 1 && cyc == 3) begin
            CoreAddr = 8'd50; CoreDataIn = 8'hAA; CoreWriteEn = 1'b1;
            SrcAddr = 8'd0; DstAddr = 8'd0; Length = 8'd3; Start = 1'b1;
         end
         if (mode == 1 && cyc == 7) begin
            CoreWriteEn = 1'b0; Start = 1'b0;
         end
         @(posedge Clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, 2 * int'(len) + 1);
      chk({tag, "_busy_during"}, {31'd0, busy_ok & Busy}, 32'd1);
      @(posedge Clk); #1;
      chk({tag, "_done_low"}, {31'd0, Done}, 32'd0);
      chk({tag, "_busy_low"}, {31'd0, Busy}, 32'd0);
      chk({tag, "_one_done"}, done_cnt - d0, 32'd1);
      chk({tag, "_queues_empty"}, rq.size() + wq.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] pre [9];
      pre = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6a, 8'h69, 8'h5c, 8'h7e, 8'h7b};

      // Reset state with passthrough on
      CoreAddr = 8'd33;
      #2;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_addr", {24'd0, MemAddress}, 32'd33);
      chk("rst_we", {31'd0, MemWriteEn}, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;

      // Idle passthrough write and read-back
      @(negedge Clk);
      CoreAddr = 8'd77; CoreDataIn = 8'h5A; CoreWriteEn = 1'b1;
      #1;
      chk("pass_addr", {24'd0, MemAddress}, 32'd77);
      chk("pass_we", {31'd0, MemWriteEn}, 32'd1);
      chk("pass_data", {24'd0, MemDataOut}, 32'h5A);
      @(negedge Clk);
      CoreWriteEn = 1'b0;
      #1;
      chk("pass_rdback", {24'd0, CoreDataOut}, 32'h5A);

      // Preload source, clear destination
      for (int i = 0; i < 9; i++) core_write(8'(200 + i), pre[i]);
      for (int i = 0; i < 9; i++) core_write(8'(100 + i), 8'h00);

      // Reset in cycle 5 of the 9-byte copy
      run_copy(8'd200, 8'd100, 8'd9, 2, "abort");
      chk("abort_m100", {24'd0, mem[100]}, 32'h60);
      chk("abort_m101", {24'd0, mem[101]}, 32'h48);
      for (int i = 102; i < 109; i++) chk("abort_untouched", {24'd0, mem[i]}, 32'h00);

      // Forward copy, 9 bytes
      run_copy(8'd200, 8'd100, 8'd9, 0, "fwd");
      for (int i = 0; i < 9; i++) chk("fwd_data", {24'd0, mem[100 + i]}, {24'd0, pre[i]});

      // Overlapping backward copy
      run_copy(8'd200, 8'd202, 8'd4, 0, "back");
      for (int i = 0; i < 4; i++) chk("back_data", {24'd0, mem[202 + i]}, {24'd0, pre[i]});

      // Source range wrapping 255 -> 0
      core_write(8'd254, 8'h11);
      core_write(8'd255, 8'h22);
      core_write(8'd0, 8'h33);
      core_write(8'd1, 8'h44);
      run_copy(8'd254, 8'd10, 8'd4, 0, "wrap");
      chk("wrap_m10", {24'd0, mem[10]}, 32'h11);
      chk("wrap_m11", {24'd0, mem[11]}, 32'h22);
      chk("wrap_m12", {24'd0, mem[12]}, 32'h33);
      chk("wrap_m13", {24'd0, mem[13]}, 32'h44);

      // Zero-length request
      run_copy(8'd200, 8'd100, 8'd0, 0, "len0");
      chk("len0_nochange", {24'd0, mem[100]}, 32'h60);

      // Core write and a second Start while the engine is busy
      core_write(8'd50, 8'h33);
      run_copy(8'd200, 8'd150, 8'd5, 1, "dist");
      chk("dist_m50", {24'd0, mem[50]}, 32'h33);
      repeat (10) @(negedge Clk);
      chk("dist_no_second", {31'd0, Busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
